// File: rtl/i8088_axi_io_slave.sv
// AXI4-Lite peripheral window for the 8088 bridge: LED, scratch, periodic timer
// and the timer interrupt driven toward the CPU.
module i8088_axi_io_slave #(
    parameter int unsigned ADDR_BITS    = 5,
    parameter logic [3:0]  RESET_LED    = 4'h0,
    parameter logic [31:0] RESET_PERIOD = 32'd999
) (
    input  logic        AXI_CLK,
    input  logic        RESETN,
    input  logic [31:0] AXI_awaddr,
    input  logic [2:0]  AXI_awprot,
    input  logic        AXI_awvalid,
    output logic        AXI_awready,
    input  logic [31:0] AXI_wdata,
    input  logic [3:0]  AXI_wstrb,
    input  logic        AXI_wvalid,
    output logic        AXI_wready,
    output logic [1:0]  AXI_bresp,
    output logic        AXI_bvalid,
    input  logic        AXI_bready,
    input  logic [31:0] AXI_araddr,
    input  logic [2:0]  AXI_arprot,
    input  logic        AXI_arvalid,
    output logic        AXI_arready,
    output logic [31:0] AXI_rdata,
    output logic [1:0]  AXI_rresp,
    output logic        AXI_rvalid,
    input  logic        AXI_rready,
    output logic [3:0]  LED,
    output logic        INTR_cpu
);

    localparam int unsigned IdxW = ADDR_BITS - 2;

    typedef enum logic [2:0] {
        RegLed, RegScratch, RegCount, RegPeriod, RegCtrl, RegStatus, RegNone
    } reg_e;

    // Word index inside the window; indices 6 and up are unmapped.
    function automatic reg_e decode(input logic [IdxW-1:0] idx);
        if (idx == IdxW'(0)) return RegLed;
        if (idx == IdxW'(1)) return RegScratch;
        if (idx == IdxW'(2)) return RegCount;
        if (idx == IdxW'(3)) return RegPeriod;
        if (idx == IdxW'(4)) return RegCtrl;
        if (idx == IdxW'(5)) return RegStatus;
        return RegNone;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    logic            aw_full_q, w_full_q, bvalid_q, rvalid_q;
    logic [IdxW-1:0] aw_idx_q;
    logic [31:0]     w_data_q;
    logic [3:0]      w_strb_q;
    logic [1:0]      bresp_q, rresp_q;
    logic [31:0]     rdata_q;
    logic [3:0]      led_q;
    logic [31:0]     scratch_q, count_q, period_q;
    logic [1:0]      ctrl_q;
    logic            pending_q;

    logic        aw_hs, w_hs, ar_hs, commit, expire, rd_err;
    logic [31:0] rd_data;
    reg_e        wr_reg, rd_reg;

    logic unused_bits;
    assign unused_bits = ^{AXI_awprot, AXI_arprot, AXI_awaddr[31:ADDR_BITS], AXI_awaddr[1:0],
                           AXI_araddr[31:ADDR_BITS], AXI_araddr[1:0]};

    assign AXI_awready = !aw_full_q && !bvalid_q;
    assign AXI_wready  = !w_full_q && !bvalid_q;
    assign AXI_arready = !rvalid_q;
    assign AXI_bvalid  = bvalid_q;
    assign AXI_bresp   = bresp_q;
    assign AXI_rvalid  = rvalid_q;
    assign AXI_rdata   = rdata_q;
    assign AXI_rresp   = rresp_q;
    assign LED         = led_q;
    assign INTR_cpu    = pending_q && ctrl_q[1];

    assign aw_hs  = AXI_awvalid && AXI_awready;
    assign w_hs   = AXI_wvalid && AXI_wready;
    assign ar_hs  = AXI_arvalid && AXI_arready;
    assign commit = aw_full_q && w_full_q && !bvalid_q;
    assign expire = ctrl_q[0] && (count_q == period_q);
    assign wr_reg = decode(aw_idx_q);
    assign rd_reg = decode(AXI_araddr[ADDR_BITS-1:2]);

    // Read mux over current register state (pre-edge values).
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_reg)
            RegLed:     rd_data = {28'd0, led_q};
            RegScratch: rd_data = scratch_q;
            RegCount:   rd_data = count_q;
            RegPeriod:  rd_data = period_q;
            RegCtrl:    rd_data = {30'd0, ctrl_q};
            RegStatus:  rd_data = {31'd0, pending_q};
            default:    rd_err  = 1'b1;
        endcase
    end

    // Write channel: independent AW/W slots, commit once both are full.
    always_ff @(posedge AXI_CLK or negedge RESETN) begin
        if (!RESETN) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else if (commit) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (wr_reg == RegNone) ? 2'b10 : 2'b00;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= AXI_awaddr[ADDR_BITS-1:2];
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= AXI_wdata;
                w_strb_q <= AXI_wstrb;
            end
            if (bvalid_q && AXI_bready) bvalid_q <= 1'b0;
        end
    end

    // Register file and timer; a PERIOD write overrides the count update.
    always_ff @(posedge AXI_CLK or negedge RESETN) begin
        if (!RESETN) begin
            led_q     <= RESET_LED;
            scratch_q <= '0;
            count_q   <= '0;
            period_q  <= RESET_PERIOD;
            ctrl_q    <= 2'b00;
            pending_q <= 1'b0;
        end else begin
            if (ctrl_q[0]) count_q <= expire ? 32'd0 : count_q + 32'd1;
            // Expiry wins over a simultaneous write-1-to-clear.
            if (expire) begin
                pending_q <= 1'b1;
            end else if (commit && wr_reg == RegStatus && w_strb_q[0] && w_data_q[0]) begin
                pending_q <= 1'b0;
            end
            if (commit) begin
                case (wr_reg)
                    RegLed:     if (w_strb_q[0]) led_q <= w_data_q[3:0];
                    RegScratch: scratch_q <= merge(scratch_q, w_data_q, w_strb_q);
                    RegPeriod: begin
                        period_q <= merge(period_q, w_data_q, w_strb_q);
                        count_q  <= 32'd0;
                    end
                    RegCtrl:    if (w_strb_q[0]) ctrl_q <= w_data_q[1:0];
                    default:    ;
                endcase
            end
        end
    end

    // Read channel: one-cycle latency, response held until rready.
    always_ff @(posedge AXI_CLK or negedge RESETN) begin
        if (!RESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? 2'b10 : 2'b00;
        end else if (rvalid_q && AXI_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i8088_axi_io_slave.sv
// Bench for i8088_axi_io_slave: transaction-level model checked every cycle plus
// directed transactions with literal expectations.
module tb_i8088_axi_io_slave;

    localparam logic [3:0] TbResetLed = 4'h3;

    logic        AXI_CLK = 1'b0;
    logic        RESETN;
    logic [31:0] AXI_awaddr, AXI_wdata, AXI_araddr, AXI_rdata;
    logic [2:0]  AXI_awprot, AXI_arprot;
    logic        AXI_awvalid, AXI_awready, AXI_wvalid, AXI_wready, AXI_bvalid, AXI_bready;
    logic        AXI_arvalid, AXI_arready, AXI_rvalid, AXI_rready, INTR_cpu;
    logic [3:0]  AXI_wstrb, LED;
    logic [1:0]  AXI_bresp, AXI_rresp;

    int vectors = 0;
    int miscompares = 0;

    i8088_axi_io_slave #(
        .ADDR_BITS(5),
        .RESET_LED(TbResetLed),
        .RESET_PERIOD(32'd999)
    ) dut (
        .AXI_CLK(AXI_CLK), .RESETN(RESETN),
        .AXI_awaddr(AXI_awaddr), .AXI_awprot(AXI_awprot), .AXI_awvalid(AXI_awvalid),
        .AXI_awready(AXI_awready),
        .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb), .AXI_wvalid(AXI_wvalid),
        .AXI_wready(AXI_wready),
        .AXI_bresp(AXI_bresp), .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready),
        .AXI_araddr(AXI_araddr), .AXI_arprot(AXI_arprot), .AXI_arvalid(AXI_arvalid),
        .AXI_arready(AXI_arready),
        .AXI_rdata(AXI_rdata), .AXI_rresp(AXI_rresp), .AXI_rvalid(AXI_rvalid),
        .AXI_rready(AXI_rready),
        .LED(LED), .INTR_cpu(INTR_cpu)
    );

    always #5 AXI_CLK = ~AXI_CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_aw_full, m_w_full, m_bvalid, m_rvalid, m_pend;
    int          m_aw_idx;
    logic [31:0] m_wdata, m_rdata, m_scratch, m_count, m_period;
    logic [3:0]  m_wstrb, m_led;
    logic [1:0]  m_bresp, m_rresp, m_ctrl;

    task automatic model_reset();
        m_aw_full = 0; m_w_full = 0; m_bvalid = 0; m_rvalid = 0; m_pend = 0;
        m_aw_idx = 0; m_wdata = 0; m_wstrb = 0; m_rdata = 0;
        m_bresp = 0; m_rresp = 0;
        m_led = TbResetLed; m_scratch = 0; m_count = 0; m_period = 32'd999; m_ctrl = 0;
    endtask

    function automatic logic [32:0] model_read(input int idx);
        case (idx)
            0: return {1'b0, 28'd0, m_led};
            1: return {1'b0, m_scratch};
            2: return {1'b0, m_count};
            3: return {1'b0, m_period};
            4: return {1'b0, 30'd0, m_ctrl};
            5: return {1'b0, 31'd0, m_pend};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    // Advance the model across the coming rising edge, using the inputs now applied.
    task automatic model_step();
        logic aw_hs, w_hs, ar_hs, commit, expire;
        logic [32:0] rd;
        aw_hs  = AXI_awvalid && !m_aw_full && !m_bvalid;
        w_hs   = AXI_wvalid && !m_w_full && !m_bvalid;
        ar_hs  = AXI_arvalid && !m_rvalid;
        commit = m_aw_full && m_w_full && !m_bvalid;
        expire = m_ctrl[0] && (m_count == m_period);
        if (ar_hs) begin
            rd = model_read(int'(AXI_araddr[4:2]));
            m_rvalid = 1; m_rdata = rd[31:0]; m_rresp = rd[32] ? 2'b10 : 2'b00;
        end else if (m_rvalid && AXI_rready) begin
            m_rvalid = 0;
        end
        if (m_bvalid && AXI_bready) m_bvalid = 0;
        if (m_ctrl[0]) m_count = expire ? 32'd0 : m_count + 32'd1;
        if (commit) begin
            m_bvalid = 1;
            m_bresp  = (m_aw_idx > 5) ? 2'b10 : 2'b00;
            case (m_aw_idx)
                0: if (m_wstrb[0]) m_led = m_wdata[3:0];
                1: m_scratch = bytes_merge(m_scratch, m_wdata, m_wstrb);
                3: begin m_period = bytes_merge(m_period, m_wdata, m_wstrb); m_count = 0; end
                4: if (m_wstrb[0]) m_ctrl = m_wdata[1:0];
                5: if (m_wstrb[0] && m_wdata[0]) m_pend = 0;
                default: ;
            endcase
            m_aw_full = 0; m_w_full = 0;
        end
        if (expire) m_pend = 1;
        if (aw_hs) begin m_aw_full = 1; m_aw_idx = int'(AXI_awaddr[4:2]); end
        if (w_hs) begin m_w_full = 1; m_wdata = AXI_wdata; m_wstrb = AXI_wstrb; end
    endtask

    // Compare process: every falling edge, outputs against the model.
    initial begin
        model_reset();
        forever begin
            @(negedge AXI_CLK);
            if (!RESETN) model_reset();
            chk("awready", AXI_awready, !m_aw_full && !m_bvalid);
            chk("wready", AXI_wready, !m_w_full && !m_bvalid);
            chk("bvalid", AXI_bvalid, m_bvalid);
            chk("bresp", AXI_bresp, m_bresp);
            chk("arready", AXI_arready, !m_rvalid);
            chk("rvalid", AXI_rvalid, m_rvalid);
            chk("rdata", AXI_rdata, m_rdata);
            chk("rresp", AXI_rresp, m_rresp);
            chk("led", LED, m_led);
            chk("intr", INTR_cpu, m_pend && m_ctrl[1]);
            if (RESETN) model_step();
        end
    end

    // ---------------- stimulus ----------------
    // Starts just after a rising edge; returns just after the B handshake edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output int lat);
        logic aw_done, w_done, a, w;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        AXI_awaddr = addr; AXI_wdata = data; AXI_wstrb = strb;
        AXI_awvalid = 1; AXI_wvalid = 1;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge AXI_CLK);
            a = AXI_awvalid && AXI_awready;
            w = AXI_wvalid && AXI_wready;
            @(posedge AXI_CLK); #1;
            if (a) begin aw_done = 1; AXI_awvalid = 0; end
            if (w) begin w_done = 1; AXI_wvalid = 0; end
            n++;
        end
        chk("write_handshakes", {30'd0, aw_done, w_done}, 32'd3);
        lat = 0;
        while (lat < 20) begin
            @(negedge AXI_CLK);
            lat++;
            if (AXI_bvalid) break;
        end
        chk("bvalid_seen", AXI_bvalid, 1);
        resp = AXI_bresp;
        @(posedge AXI_CLK); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        logic hs;
        int n;
        hs = 0; n = 0;
        AXI_araddr = addr; AXI_arvalid = 1;
        while (!hs && n < 20) begin
            @(negedge AXI_CLK);
            hs = AXI_arready;
            @(posedge AXI_CLK); #1;
            n++;
        end
        AXI_arvalid = 0;
        chk("read_handshake", hs, 1);
        lat = 0;
        while (lat < 20) begin
            @(negedge AXI_CLK);
            lat++;
            if (AXI_rvalid) break;
        end
        chk("rvalid_seen", AXI_rvalid, 1);
        data = AXI_rdata; resp = AXI_rresp;
        @(posedge AXI_CLK); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge AXI_CLK); #1; end
    endtask

    initial begin
        logic [31:0] d, v1, v2;
        logic [1:0]  r;
        int          lat, zeros;
        logic [31:0] c [4];

        RESETN = 0;
        AXI_awaddr = 0; AXI_awprot = 0; AXI_awvalid = 0;
        AXI_wdata = 0; AXI_wstrb = 0; AXI_wvalid = 0; AXI_bready = 1;
        AXI_araddr = 0; AXI_arprot = 0; AXI_arvalid = 0; AXI_rready = 1;
        repeat (2) @(posedge AXI_CLK);
        #1 RESETN = 1;

        // Reset state
        chk("reset_led", LED, 32'h3);
        chk("reset_bvalid", AXI_bvalid, 0);
        chk("reset_rvalid", AXI_rvalid, 0);
        axi_read(32'h0C, d, r, lat);
        chk("reset_period", d, 32'd999);
        axi_read(32'h04, d, r, lat);
        chk("reset_scratch", d, 32'h0);

        // LED write with AW and W together, then readback
        axi_write(32'h00, 32'h5A, 4'h1, r, lat);
        chk("led_wr_bresp", r, 2'b00);
        chk("led_wr_latency", lat, 2);
        chk("led_value", LED, 32'hA);
        axi_read(32'h00, d, r, lat);
        chk("led_rd_data", d, 32'h0000000A);
        chk("led_rd_resp", r, 2'b00);
        chk("led_rd_latency", lat, 1);
        axi_write(32'h00, 32'h5, 4'h2, r, lat);   // strobe misses the LED byte
        chk("led_strb_ignored", LED, 32'hA);

        // W leads AW by 3 cycles; B held by bready low for 5 cycles
        AXI_bready = 0;
        AXI_wdata = 32'hDEADBEEF; AXI_wstrb = 4'b0101; AXI_wvalid = 1;
        @(posedge AXI_CLK); #1 AXI_wvalid = 0;
        idle(2);
        AXI_awaddr = 32'h04; AXI_awvalid = 1;
        @(posedge AXI_CLK); #1 AXI_awvalid = 0;
        @(posedge AXI_CLK); #1;
        repeat (5) begin
            @(negedge AXI_CLK);
            chk("bp_bvalid_held", AXI_bvalid, 1);
            chk("bp_awready_low", AXI_awready, 0);
            chk("bp_wready_low", AXI_wready, 0);
        end
        @(posedge AXI_CLK); #1 AXI_bready = 1;
        @(posedge AXI_CLK); #1;
        axi_read(32'h04, d, r, lat);
        chk("scratch_strb", d, 32'h00AD00EF);

        // Timer with PERIOD 3
        axi_write(32'h0C, 32'd3, 4'hF, r, lat);
        axi_write(32'h10, 32'd3, 4'h1, r, lat);
        zeros = 0;
        while (!INTR_cpu && zeros < 12) begin @(negedge AXI_CLK); zeros++; end
        chk("timer_intr_rise", INTR_cpu, 1);
        @(posedge AXI_CLK); #1;
        for (int i = 0; i < 4; i++) begin
            axi_read(32'h08, c[i], r, lat);
            idle(3);   // reads five cycles apart step COUNT by one modulo 4
        end
        for (int i = 0; i < 4; i++) chk("count_range", (c[i] < 4) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 1; i < 4; i++) chk("count_step", c[i], (c[i-1] + 1) % 4);

        // W1C race: timer restarts from 0 at CTRL commit edge E; expiries at E+4, E+8, ...
        axi_write(32'h10, 32'd2, 4'h1, r, lat);
        axi_write(32'h0C, 32'd3, 4'hF, r, lat);
        axi_write(32'h10, 32'd3, 4'h1, r, lat);   // commit at E
        idle(1);
        axi_write(32'h14, 32'd1, 4'h1, r, lat);   // commit at E+4, same edge as expiry
        chk("w1c_race_set_wins", INTR_cpu, 1);
        idle(2);
        chk("intr_before_clear", INTR_cpu, 1);
        axi_write(32'h14, 32'd1, 4'h1, r, lat);   // commit at E+9, next expiry at E+12
        zeros = 0;
        while (zeros < 10) begin
            @(negedge AXI_CLK);
            if (INTR_cpu) break;
            zeros++;
        end
        chk("w1c_low_after_bresp", zeros, 2);
        @(posedge AXI_CLK); #1;

        // Unmapped and read-only accesses
        axi_write(32'h10, 32'd0, 4'h1, r, lat);
        axi_read(32'h08, v1, r, lat);
        axi_write(32'h08, 32'h12345678, 4'hF, r, lat);
        chk("count_wr_bresp", r, 2'b00);
        axi_read(32'h08, v2, r, lat);
        chk("count_unchanged", v2, v1);
        axi_write(32'h1C, 32'hFFFFFFFF, 4'hF, r, lat);
        chk("unmapped_wr_bresp", r, 2'b10);
        axi_read(32'h04, d, r, lat);
        chk("unmapped_scratch", d, 32'h00AD00EF);
        axi_read(32'h0C, d, r, lat);
        chk("unmapped_period", d, 32'd3);
        axi_read(32'h10, d, r, lat);
        chk("unmapped_ctrl", d, 32'd0);
        chk("unmapped_led", LED, 32'hA);
        axi_read(32'h18, d, r, lat);
        chk("unmapped_rd_data", d, 32'h0);
        chk("unmapped_rd_resp", r, 2'b10);

        // Async reset with a held R response and a captured AW
        AXI_rready = 0;
        AXI_araddr = 32'h00; AXI_arvalid = 1;
        @(posedge AXI_CLK); #1 AXI_arvalid = 0;
        AXI_awaddr = 32'h04; AXI_awvalid = 1;
        @(posedge AXI_CLK); #1 AXI_awvalid = 0;
        @(negedge AXI_CLK);
        chk("pre_reset_rvalid", AXI_rvalid, 1);
        chk("pre_reset_aw_full", AXI_awready, 0);
        @(posedge AXI_CLK); #3 RESETN = 0;
        #1;
        chk("async_rvalid", AXI_rvalid, 0);
        chk("async_bvalid", AXI_bvalid, 0);
        chk("async_awready", AXI_awready, 1);
        chk("async_led", LED, {28'd0, TbResetLed});
        idle(2);
        RESETN = 1; AXI_rready = 1;
        AXI_wdata = 32'h11111111; AXI_wstrb = 4'hF; AXI_wvalid = 1;
        @(posedge AXI_CLK); #1 AXI_wvalid = 0;
        repeat (4) begin
            @(negedge AXI_CLK);
            chk("no_stale_b", AXI_bvalid, 0);
            chk("no_stale_r", AXI_rvalid, 0);
        end

        @(posedge AXI_CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
